// File: rtl/vector_serializer_if.sv
// vector_serializer_if: vector capture handshake and beat stream bundle for vector_serializer
interface vector_serializer_if #(
    parameter int NUM_INPUTS = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1
);
    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_WIDTH*NUM_INPUTS-1:0] in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH*LANES-1:0]   out_data;
    logic [IDX_W-1:0]              out_index;
    logic                          out_last;
    logic                          busy;
    logic                          done;
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, busy, done
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, busy, done
    );
endinterface

// File: rtl/vector_serializer.sv
// vector_serializer: captures a flattened vector, then streams it LANES elements per beat
module vector_serializer #(
    parameter int NUM_INPUTS = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1,
    parameter int MSB_FIRST  = 1,
    parameter int LEAD_DELAY = 1
) (
    input logic clk,
    input logic reset,
    vector_serializer_if.slave bus
);
    localparam int NUM_BEATS = NUM_INPUTS / LANES;
    localparam int IDX_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int VW        = NUM_INPUTS * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'((NUM_BEATS - 1) * LANES);
    localparam logic [IDX_W-1:0] STEP      = IDX_W'(LANES);
    localparam logic [3:0]       LEAD_LAST = 4'(LEAD_DELAY - 1);

    if ((NUM_INPUTS % LANES) != 0 || LEAD_DELAY < 0 || LEAD_DELAY > 15) begin : g_param_check
        $error("vector_serializer: NUM_INPUTS must divide by LANES and LEAD_DELAY must be 0..15");
    end

    typedef enum logic [1:0] {IDLE, LEAD, STREAM} state_t;

    state_t           state_q, state_d;
    logic [VW-1:0]    vec_q, vec_d, in_ord;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       lead_q, lead_d;
    logic             done_q, done_d;
    logic             valid, fire, last;

    // Store elements in stream order so each beat is one contiguous slice
    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_order
        assign in_ord[k*DATA_WIDTH +: DATA_WIDTH] = (MSB_FIRST != 0) ?
            bus.in_data[(NUM_INPUTS-1-k)*DATA_WIDTH +: DATA_WIDTH] :
            bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign valid = state_q == STREAM;
    assign fire  = valid && bus.out_ready;
    assign last  = idx_q == LAST_IDX;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
        lead_d  = lead_q;
        done_d  = 1'b0;
        if (state_q == IDLE && bus.in_valid) begin
            vec_d   = in_ord;
            idx_d   = '0;
            lead_d  = '0;
            state_d = (LEAD_DELAY > 0) ? LEAD : STREAM;
        end
        if (state_q == LEAD) begin
            lead_d  = lead_q + 4'd1;
            state_d = (lead_q == LEAD_LAST) ? STREAM : LEAD;
        end
        if (fire) begin
            idx_d   = last ? '0 : idx_q + STEP;
            done_d  = last;
            state_d = last ? IDLE : STREAM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            vec_q   <= '0;
            idx_q   <= '0;
            lead_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            lead_q  <= lead_d;
            done_q  <= done_d;
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.busy      = state_q != IDLE;
    assign bus.out_valid = valid;
    assign bus.out_data  = valid ? vec_q[idx_q*DATA_WIDTH +: DATA_WIDTH*LANES] : '0;
    assign bus.out_index = valid ? idx_q : '0;
    assign bus.out_last  = valid && last;
    assign bus.done      = done_q;
endmodule
